// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage; busy holds off HI/LO users.
// Build option MDU_DIVZERO_HOLD_EN: divide by zero leaves HI/LO untouched instead of {A, all-ones}.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic [31:0] nxt_hi, nxt_lo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_sdiv, b_udiv;
  logic [31:0] uq, ur, sq, sr, q_u, r_u;
  logic        div0;
`ifdef MDU_DIVZERO_HOLD_EN
  logic        res_keep;
`endif

  // Low 64 bits of the sign-extended product are the signed 32x32 product.
  always_comb begin
    div0   = (B == 32'd0);
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? -A : A;
    b_mag  = B[31] ? -B : B;
    // Divisors forced to 1 on zero so no X can leave the dividers.
    b_sdiv = div0 ? 32'd1 : b_mag;
    b_udiv = div0 ? 32'd1 : B;
    uq     = a_mag / b_sdiv;
    ur     = a_mag % b_sdiv;
    sq     = (A[31] ^ B[31]) ? -uq : uq;
    sr     = A[31] ? -ur : ur;
    q_u    = A / b_udiv;
    r_u    = A % b_udiv;
    nxt_hi = 32'd0;
    nxt_lo = 32'd0;
    case (op[1:0])
      2'd0: {nxt_hi, nxt_lo} = prod_s;
      2'd1: {nxt_hi, nxt_lo} = prod_u;
      2'd2: begin nxt_hi = sr;  nxt_lo = sq;  end
      default: begin nxt_hi = r_u; nxt_lo = q_u; end
    endcase
    if (op[1] && div0) begin
      nxt_hi = A;
      nxt_lo = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
`ifdef MDU_DIVZERO_HOLD_EN
      res_keep <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              res_hi <= nxt_hi;
              res_lo <= nxt_lo;
              cnt    <= op[1] ? DIV_N : MULT_N;
              state  <= RUN;
              busy   <= 1'b1;
`ifdef MDU_DIVZERO_HOLD_EN
              res_keep <= op[1] & div0;
`endif
            end
            3'd4:    HI <= A;
            3'd5:    LO <= A;
            default: ;
          endcase
        end
        RUN: begin
          // start is ignored here; only the countdown advances.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef MDU_DIVZERO_HOLD_EN
            if (!res_keep) begin
              HI <= res_hi;
              LO <= res_lo;
            end
`else
            HI <= res_hi;
            LO <= res_lo;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed plus randomized checks of mdu against an arithmetic reference model.
module tb_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS-level semantics with plain integer arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    int          sa, sb;
    logic [63:0] r;
    sa = int'(a);
    sb = int'(b);
    r  = {hi_m, lo_m};
    case (o)
      3'd0: begin ps = longint'(sa) * longint'(sb); r = 64'(ps); end
      3'd1: r = 64'({32'd0, a}) * 64'({32'd0, b});
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          r = {hi_m, lo_m};
`else
          r = {a, 32'hFFFF_FFFF};
`endif
        end else if (o == 3'd3) r = {a % b, a / b};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: r = {a, lo_m};
      3'd5: r = {hi_m, a};
      default: r = {hi_m, lo_m};
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [63:0] e;
    int n, nb;
    e  = ref_mdu(o, a, b);
    n  = (o <= 3'd1) ? MULT_N : (o <= 3'd3) ? DIV_N : 0;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      chk("hold_hi", HI, hi_m);
      chk("hold_lo", LO, lo_m);
      if (inject && nb == 2) begin
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0000_0007;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    hi_m = e[63:32];
    lo_m = e[31:0];
    chk($sformatf("busy_cycles_op%0d", o), 32'(nb), 32'(n));
    chk($sformatf("hi_op%0d", o), HI, hi_m);
    chk($sformatf("lo_op%0d", o), LO, lo_m);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg_hi", HI, 32'hFFFF_FFFF);
    chk("mult_neg_lo", LO, 32'hFFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", HI, 32'hFFFF_FFFF);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);
    do_op(3'd2, 32'd5, 32'd0, 1'b0);
`ifdef MDU_DIVZERO_HOLD_EN
    chk("div0_hi", HI, 32'd1);
    chk("div0_lo", LO, 32'd3);
`else
    chk("div0_hi", HI, 32'd5);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
`endif
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);

    do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_now", HI, 32'h1234_5678);
    do_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    chk("mtlo_now", LO, 32'hCAFE_F00D);
    do_op(3'd0, 32'd6, 32'd7, 1'b1);
    chk("inject_lo", LO, 32'd42);
    chk("inject_hi", HI, 32'd0);

    // Reset three cycles into a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_hi", HI, 32'd0);
    chk("async_lo", LO, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk); reset = 1'b0;
    do_op(3'd0, 32'hFFFF_FFFF, 32'd9, 1'b0);
    chk("post_reset_mult_lo", LO, 32'hFFFF_FFF7);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      do_op(ro, ra, rb, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO registers. It exposes `busy` so the hazard unit can stall any HI/LO-touching instruction held in D. It is the responder that the stall logic waits on.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU, legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU, legal range 1..15.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `start` input, 1 bit: E-stage instruction is an MDU op; sampled at posedge.
- `op` input, 3 bits: operation code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- `A` input, 32 bits: rs operand, already forwarded.
- `B` input, 32 bits: rt operand, already forwarded.
- `busy` output, 1 bit: registered; high while a mult or div is in flight.
- `HI` output, 32 bits: registered HI (read by MFHI in E).
- `LO` output, 32 bits: registered LO (read by MFLO in E).

## Operation
- States: IDLE and RUN. A 4-bit down-counter `cnt` runs in RUN; result registers `res_hi` and `res_lo` are internal.
- IDLE with `start`=1 and op 0–3:
  - Compute the 64-bit result from A and B at that edge and store it in `res_hi`/`res_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN and set `busy`=1.
- IDLE with `start`=1 and op 4: HI<=A at that edge; `busy` stays 0.
- IDLE with `start`=1 and op 5: LO<=A at that edge; `busy` stays 0.
- IDLE with op 6 or 7: no state change.
- RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt`==1: HI<=`res_hi`, LO<=`res_lo`, `busy`<=0, go to IDLE.
- `start` in RUN, any op: ignored. The hazard unit guarantees this never occurs; the MDU must not corrupt state if it does.
- HI/LO keep their old values throughout RUN; they update only at completion.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits; {HI,LO} = product.
  - MULTU: unsigned 32x32 to 64 bits; {HI,LO} = product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (B==0): behaviour set by the configuration macro. `busy` timing is the same as for any DIV.

## Timing
- Reset values: `busy`=0, HI=0, LO=0, state IDLE, `cnt`=0.
- Reset asserted mid-operation aborts at once: `busy` drops asynchronously and HI/LO clear to 0. The pending result is discarded.
- Mult/div accepted at edge t:
  - `busy`=1 during cycles t+1 through t+N, where N is the op's cycle count.
  - HI/LO take the new value at edge t+N.
  - `busy` is 0 from cycle t+N+1 onward.
  - A new `start` is accepted at edge t+N+1 at the earliest.
- MTHI/MTLO: single-edge write, zero busy cycles. A following MFHI/MFLO in E on the next cycle reads the new value.
- The hazard unit forms stall = D_is_MDU_op & (E `start`[op 0–3] | `busy`); that logic is outside this block. `busy` is registered, so there is no combinational path from the inputs to `busy`.

## Configuration
- `MDU_DIVZERO_HOLD_EN` defined: DIV/DIVU with B==0 leaves HI and LO unchanged at completion; `busy` still runs the full `DIV_CYCLES`.
- `MDU_DIVZERO_HOLD_EN` undefined: DIV/DIVU with B==0 writes LO=0xFFFFFFFF and HI=A at completion. X from Verilog division must never reach HI/LO.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE and B=3 → `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF and B=0xFFFFFFFF → after 5 busy cycles, HI=0xFFFFFFFE and LO=0x00000001.
- DIV with A=-7 (0xFFFFFFF9) and B=2 → `busy` high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with A=7, B=2 → LO=3, HI=1.
- DIV with A=5 and B=0:
  - Macro defined: HI and LO keep their prior values.
  - Macro undefined: LO=0xFFFFFFFF, HI=5.
  - Both builds: `busy` lasts 10 cycles.
- MTHI with A=0x12345678, then a second `start` with op=0 pulsed during RUN → HI=0x12345678 immediately after the MTHI edge, and the in-RUN start has no effect on HI/LO, `cnt` or `busy`.
- Assert `reset` 3 cycles into a DIV → `busy`, HI and LO go to 0 asynchronously. After release, the unit sits in IDLE and accepts a new MULT on the first edge.
